// File: rtl/seg_pkg.sv
// seg_pkg: page encodings and the active-low seven-segment glyph table
// shared by seg_display_driver and hex_to_seg7.
package seg_pkg;

    typedef enum logic [1:0] {
        PAGE_VAL = 2'd0,
        PAGE_PC  = 2'd1,
        PAGE_XY  = 2'd2,
        PAGE_OFF = 2'd3
    } page_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the {g,f,e,d,c,b,a} active-low pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_GLYPHS[i_nibble];

endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: snapshots four debug buses and scans one page onto an
// 8-digit common-anode display. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic [31:0] coord_x,
    input  logic [31:0] coord_y,
    input  logic [31:0] value_in,
    input  logic [31:0] pc_in,
    input  logic [1:0]  page_sel,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int               CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [31:0]      r_snap_x;
    logic [31:0]      r_snap_y;
    logic [31:0]      r_snap_val;
    logic [31:0]      r_snap_pc;
    logic [CNT_W-1:0] r_ref_cnt;
    logic [2:0]       r_digit_idx;
    page_e            r_page_q;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;

    logic             w_wrap;
    logic             w_frame_end;
    logic [31:0]      w_word;
    logic [3:0]       w_nibble;
    logic [6:0]       w_glyph;
    logic             w_lz_blank;
    logic             w_unused_hi;

    assign w_wrap      = (r_ref_cnt == CNT_MAX);
    assign w_frame_end = w_wrap && (r_digit_idx == 3'd7);

    // The coordinate page only ever shows the low halves.
    assign w_unused_hi = ^{r_snap_x[31:16], r_snap_y[31:16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_x   <= '0;
            r_snap_y   <= '0;
            r_snap_val <= '0;
            r_snap_pc  <= '0;
        end else if (update) begin
            r_snap_x   <= coord_x;
            r_snap_y   <= coord_y;
            r_snap_val <= value_in;
            r_snap_pc  <= pc_in;
        end
    end

    // Page only changes at a frame boundary so a scan is never torn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt   <= '0;
            r_digit_idx <= '0;
            r_page_q    <= PAGE_VAL;
        end else begin
            if (w_wrap) begin
                r_ref_cnt   <= '0;
                r_digit_idx <= r_digit_idx + 3'd1;
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
            if (w_frame_end) begin
                r_page_q <= page_e'(page_sel);
            end
        end
    end

    always_comb begin
        w_word = r_snap_val;
        case (r_page_q)
            PAGE_PC: w_word = r_snap_pc;
            PAGE_XY: w_word = {r_snap_x[15:0], r_snap_y[15:0]};
            default: w_word = r_snap_val;
        endcase
    end

    assign w_nibble = w_word[{r_digit_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] w_msd;

    // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 is lit.
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w_word[4*i +: 4] != 4'h0) begin
                w_msd = 3'(i);
            end
        end
    end

    assign w_lz_blank = (r_page_q != PAGE_XY) && (r_digit_idx > w_msd);
`else
    assign w_lz_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 8'hFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if ((r_page_q == PAGE_OFF) || w_lz_blank) begin
            r_an  <= 8'hFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(8'b1 << r_digit_idx);
            r_seg <= w_glyph;
            r_dp  <= !((r_page_q == PAGE_XY) && (r_digit_idx == 3'd4));
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: doc/seg_display_driver.md
# seg_display_driver

Board-side consumer of the processor's debug outputs (X/Y coordinate result, value display, PC display). It snapshots the four 32-bit buses on an update strobe and time-multiplexes one selected page onto an 8-digit common-anode seven-segment display. It sits between the top-level processor and the FPGA pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Must be ≥ 2.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `update` input, 1 bit: snapshot strobe. Captures all four data buses on every cycle it is high.
- `coord_x` input, 32 bits: X coordinate from the processor.
- `coord_y` input, 32 bits: Y coordinate from the processor.
- `value_in` input, 32 bits: value display bus.
- `pc_in` input, 32 bits: PC display bus.
- `page_sel` input, 2 bits: selects the page. 0 = value, 1 = PC, 2 = coordinates, 3 = blank.
- `an` output, 8 bits: active-low digit enables, one-hot-low. `an[0]` is the rightmost digit.
- `seg` output, 7 bits: active-low segments `{g,f,e,d,c,b,a}`.
- `dp` output, 1 bit: active-low decimal point.

## Operation
- **Snapshot registers** `snap_x/y/val/pc`: loaded from the inputs on any cycle with `update=1`. Otherwise they hold.
- **Refresh counter** `ref_cnt`, width `$clog2(REFRESH_DIV)`:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On each wrap, `digit_idx` (3 bits) increments, wrapping from 7 to 0.
- **Frame boundary**: the cycle where `ref_cnt` wraps and `digit_idx==7`. At this point, and only here, `page_sel` is latched into `page_q`. This prevents a torn display mid-scan.
- **Nibble select** for digit `d`:
  - Page 0: `snap_val[4d+3:4d]`.
  - Page 1: `snap_pc[4d+3:4d]`.
  - Page 2: digits 7..4 show `snap_x[15:0]`; digits 3..0 show `snap_y[15:0]`.
- **Decoding**: nibbles map to hex glyphs 0–F through `hex_to_seg7`.
- **Decimal point**: `dp=0` only on page 2, digit 4. Otherwise `dp=1`.
- **Page 3**: `an=8'hFF`, `seg=7'h7F`.
- **Simultaneous events**:
  - `update` and a page change together: the snapshot applies immediately; the page applies at the next frame boundary.
  - `update` held high: the display tracks the inputs live.

## Timing
- **Reset values**:
  - `an=8'hFF`, `seg=7'h7F`, `dp=1`.
  - `ref_cnt=0`, `digit_idx=0`, `page_q=0`.
  - All snapshots 0.
- **Output latency**: `an/seg/dp` are registered and reflect `digit_idx`, `page_q` and the snapshots as they stood on the previous cycle (1-cycle latency).
  - First edge after `rst` falls: `an=8'hFE`.
  - Thereafter `an` changes every REFRESH_DIV cycles.
- **Snapshot to display**: a snapshot change is visible on the currently scanned digit 2 edges after the `update` edge.
- **Page change**: visible within at most 8·REFRESH_DIV + 1 cycles.
- **Reset mid-scan**: all state returns to the reset values on the next edge. Scanning restarts at digit 0 on page 0.

## Configuration
- **`LEADING_ZERO_BLANK_EN`**:
  - **Defined**: on pages 0 and 1, any digit above the most significant nonzero nibble is blanked (its `an` bit is held high). Digit 0 is always lit. The blanking mask is computed from the snapshot.
  - **Undefined**: all 8 digits are always lit on pages 0–2.
- Page 2 is never blanked, in either configuration.

## Structure
- **Package `seg_pkg`**:
  - Page encodings: `PAGE_VAL=2'd0`, `PAGE_PC=2'd1`, `PAGE_XY=2'd2`, `PAGE_OFF=2'd3`.
  - The 16-entry active-low glyph table: `0=7'h40`, `1=7'h79`, `2=7'h24`, `3=7'h30`, `4=7'h19`, `5=7'h12`, `6=7'h02`, `7=7'h78`, `8=7'h00`, `9=7'h10`, `A=7'h08`, `b=7'h03`, `C=7'h46`, `d=7'h21`, `E=7'h06`, `F=7'h0E`.
  - `SEG_BLANK=7'h7F`.
- **Sub-module `hex_to_seg7`**: combinational, 4-bit nibble in, 7-bit seg out, table from `seg_pkg`.

## Test plan
All scenarios use `REFRESH_DIV=4`.
1. **Reset**: hold `rst=1` for 3 cycles, then release → during reset `an=FF`, `seg=7F`, `dp=1`; first edge after release `an=FE`; `an` steps FE→FD→FB… every 4 cycles and wraps to FE after 32 cycles.
2. **Value page**: `value_in=32'h12345678`, 1-cycle `update`, `page_sel=0` → `an=FE` shows `seg=7'h00` (8), `an=7F` shows `seg=7'h79` (1), `dp=1` throughout.
3. **Coordinate page**: `coord_x=32'h00AB0012`, `coord_y=32'h0000CDEF`, update, `page_sel=2` (after frame boundary) → digits 7..4 show 0,0,1,2; digits 3..0 show C,d,E,F; `dp=0` only while `an=EF`.
4. **Page change mid-frame**: switch `page_sel` 0→1 while `digit_idx=3` → digits 3..7 still show value; PC appears starting at digit 0 of the next frame.
5. **Leading-zero blanking**: with `LEADING_ZERO_BLANK_EN`, `value_in=32'h000000A5` → only `an=FE` and `an=FD` go low; all others stay high. With value 0, only digit 0 is lit, showing `7'h40`. Without the macro, all 8 digits are lit.
6. **Reset mid-scan plus page 3**: assert `rst` at `digit_idx=5` → next edge `an=FF` and snapshots cleared. Then `page_sel=3` → after the frame boundary, `an` stays FF and `seg` stays 7F.
